// File: rtl/uart_tx_frame_gen.sv
// uart_tx_frame_gen
//   Serial UART transmitter. Serialises a parallel byte LSB-first as
//   start(0), DATA_WIDTH data bits, optional parity bit, stop(1).
//   Each bit lasts N CLK cycles, where N is the latched Prescale value
//   (values 0 and 1 both give N = 1).
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous reset, active-low
//   P_DATA      byte to send, latched at acceptance
//   Data_Valid  send request, accepted in IDLE
//   PAR_EN      1 = insert parity bit, latched at acceptance
//   PAR_TYP     0 = even, 1 = odd, latched at acceptance
//   Prescale    CLK cycles per bit, latched at acceptance
//   TX_OUT      registered serial line, idles high
//   busy        registered, 1 while a frame is in progress
//
// Build option
//   UART_TX_HOLD_BUF_EN: one-entry holding register. A request arriving
//   while busy is parked there and launched straight from the last STOP
//   cycle, so chained frames keep busy high. Further requests while the
//   holding register is full are dropped.

module uart_tx_frame_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  shadow_q, shadow_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;

  logic [PRESC_WIDTH-1:0] last_cnt;
  logic                   bit_done;
  logic                   launch;
  logic [DATA_WIDTH-1:0]  ld_data;
  logic                   ld_pen;
  logic                   ld_ptyp;
  logic [PRESC_WIDTH-1:0] ld_presc;

`ifdef UART_TX_HOLD_BUF_EN
  logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
  logic                   hold_pen_q, hold_pen_d;
  logic                   hold_ptyp_q, hold_ptyp_d;
  logic [PRESC_WIDTH-1:0] hold_presc_q, hold_presc_d;
  logic                   hold_full_q, hold_full_d;
`endif

  // Prescale 0 and 1 both collapse to a one-cycle bit.
  assign last_cnt = (presc_q > PRESC_WIDTH'(1)) ? presc_q - PRESC_WIDTH'(1) : '0;
  assign bit_done = (cnt_q == last_cnt);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    presc_d   = presc_q;
    shadow_d  = shadow_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    launch    = 1'b0;
    ld_data   = P_DATA;
    ld_pen    = PAR_EN;
    ld_ptyp   = PAR_TYP;
    ld_presc  = Prescale;
`ifdef UART_TX_HOLD_BUF_EN
    hold_data_d  = hold_data_q;
    hold_pen_d   = hold_pen_q;
    hold_ptyp_d  = hold_ptyp_q;
    hold_presc_d = hold_presc_q;
    hold_full_d  = hold_full_q;

    // Park a request that arrives mid-frame; checked before the launch
    // below so a same-cycle chain launch still wins over a new park.
    if (Data_Valid && busy_q && !hold_full_q) begin
      hold_data_d  = P_DATA;
      hold_pen_d   = PAR_EN;
      hold_ptyp_d  = PAR_TYP;
      hold_presc_d = Prescale;
      hold_full_d  = 1'b1;
    end
`endif

    if (state_q != S_IDLE) begin
      cnt_d = bit_done ? '0 : cnt_q + PRESC_WIDTH'(1);
    end

    unique case (state_q)
      S_IDLE: begin
`ifdef UART_TX_HOLD_BUF_EN
        // A held frame can only be pending here if it was parked on the
        // very last STOP cycle; it takes priority over a fresh request.
        if (hold_full_q) begin
          launch      = 1'b1;
          ld_data     = hold_data_q;
          ld_pen      = hold_pen_q;
          ld_ptyp     = hold_ptyp_q;
          ld_presc    = hold_presc_q;
          hold_full_d = 1'b0;
        end else if (Data_Valid) begin
          launch = 1'b1;
        end
`else
        if (Data_Valid) begin
          launch = 1'b1;
        end
`endif
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
`ifdef UART_TX_HOLD_BUF_EN
          if (hold_full_q) begin
            launch      = 1'b1;
            ld_data     = hold_data_q;
            ld_pen      = hold_pen_q;
            ld_ptyp     = hold_ptyp_q;
            ld_presc    = hold_presc_q;
            hold_full_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d   = S_START;
      cnt_d     = '0;
      idx_d     = '0;
      shadow_d  = ld_data;
      par_en_d  = ld_pen;
      par_bit_d = ld_ptyp ? ~(^ld_data) : ^ld_data;
      presc_d   = ld_presc;
    end
  end

  // Line value is decoded from the next state so TX_OUT is a pure flop.
  always_comb begin
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shadow_d[idx_d];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      presc_q   <= '0;
      shadow_q  <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
      hold_data_q  <= '0;
      hold_pen_q   <= 1'b0;
      hold_ptyp_q  <= 1'b0;
      hold_presc_q <= '0;
      hold_full_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      shadow_q  <= shadow_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_HOLD_BUF_EN
      hold_data_q  <= hold_data_d;
      hold_pen_q   <= hold_pen_d;
      hold_ptyp_q  <= hold_ptyp_d;
      hold_presc_q <= hold_presc_d;
      hold_full_q  <= hold_full_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Testbench for uart_tx_frame_gen. Expected line waveforms are built from
// the frame rules (start, LSB-first data, parity from a ones count, stop,
// each bit repeated N cycles) and compared cycle by cycle.

module tb_uart_tx_frame_gen;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame_gen #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .Prescale   (prescale),
    .TX_OUT     (tx_out),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Append the full per-cycle line waveform of one frame to exp_q.
  task automatic build_frame(input logic [DW-1:0] data, input bit pen, input bit ptyp,
                             input int unsigned presc);
    int unsigned n;
    bit          bits[$];
    bit          odd_ones;
    n        = (presc < 2) ? 1 : presc;
    odd_ones = ($countones(data) % 2) == 1;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(data[i]);
    if (pen) bits.push_back(ptyp ? !odd_ones : odd_ones);
    bits.push_back(1'b1);
    foreach (bits[i]) for (int unsigned k = 0; k < n; k++) exp_q.push_back(bits[i]);
  endtask

  task automatic drive_req(input logic [DW-1:0] data, input bit pen, input bit ptyp,
                           input logic [PW-1:0] presc);
    p_data     = data;
    par_en     = pen;
    par_typ    = ptyp;
    prescale   = presc;
    data_valid = 1'b1;
  endtask

  task automatic scramble_inputs();
    p_data   = DW'($urandom);
    par_en   = 1'($urandom);
    par_typ  = 1'($urandom);
    prescale = PW'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_req(8'hFF, 1'b1, 1'b1, 6'd3);
    repeat (3) tick();
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_state tx=%b busy=%b required tx=1 busy=0", tx_out, busy);
    else n_pass++;
    data_valid = 1'b0;
    rst_n      = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_after_reset tx=%b busy=%b required tx=1 busy=0", tx_out, busy);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [DW-1:0] d_tab[6]  = '{8'hA5, 8'h00, 8'hFF, 8'h5A, 8'hC3, 8'h81};
    bit            pe_tab[6] = '{1, 1, 0, 1, 0, 1};
    bit            pt_tab[6] = '{0, 1, 0, 1, 0, 0};
    logic [PW-1:0] ps_tab[6] = '{6'd8, 6'd16, 6'd16, 6'd0, 6'd1, 6'd63};
    for (int t = 0; t < 6; t++) begin
      exp_q.delete();
      build_frame(d_tab[t], pe_tab[t], pt_tab[t], ps_tab[t]);
      drive_req(d_tab[t], pe_tab[t], pt_tab[t], ps_tab[t]);
      tick();
      data_valid = 1'b0;
      scramble_inputs();
      for (int c = 0; c < exp_q.size(); c++) begin
        n_checks++;
        if (tx_out !== exp_q[c] || busy !== 1'b1)
          $display("FAIL directed%0d cyc=%0d tx=%b busy=%b required tx=%b busy=1",
                   t, c, tx_out, busy, exp_q[c]);
        else n_pass++;
        tick();
      end
      n_checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0)
        $display("FAIL directed%0d_end tx=%b busy=%b required tx=1 busy=0", t, tx_out, busy);
      else n_pass++;
      tick();
    end
  endtask

  // Second request lands in the first idle cycle: exactly one idle cycle
  // (line high, busy low) separates the stop bit from the next start bit.
  task automatic test_back_to_back();
    logic [DW-1:0] d_tab[2] = '{8'h3C, 8'hC3};
    for (int f = 0; f < 2; f++) begin
      exp_q.delete();
      build_frame(d_tab[f], 1'b1, 1'b0, 8);
      drive_req(d_tab[f], 1'b1, 1'b0, 6'd8);
      tick();
      data_valid = 1'b0;
      for (int c = 0; c < exp_q.size(); c++) begin
        n_checks++;
        if (tx_out !== exp_q[c] || busy !== 1'b1)
          $display("FAIL b2b%0d cyc=%0d tx=%b busy=%b required tx=%b busy=1",
                   f, c, tx_out, busy, exp_q[c]);
        else n_pass++;
        tick();
      end
      n_checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0)
        $display("FAIL b2b%0d_gap tx=%b busy=%b required tx=1 busy=0", f, tx_out, busy);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] d = 8'hA5;
    drive_req(d, 1'b1, 1'b0, 6'd4);
    tick();
    data_valid = 1'b0;
    repeat (4 * 4 + 1) tick();
    n_checks++;
    if (tx_out !== d[3] || busy !== 1'b1)
      $display("FAIL mid_bit3 tx=%b busy=%b required tx=%b busy=1", tx_out, busy, d[3]);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_reset tx=%b busy=%b required tx=1 busy=0", tx_out, busy);
    else n_pass++;
    repeat (3) begin
      tick();
      n_checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0)
        $display("FAIL mid_no_resume tx=%b busy=%b required tx=1 busy=0", tx_out, busy);
      else n_pass++;
    end
    exp_q.delete();
    build_frame(8'h96, 1'b1, 1'b1, 3);
    drive_req(8'h96, 1'b1, 1'b1, 6'd3);
    tick();
    data_valid = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      n_checks++;
      if (tx_out !== exp_q[c] || busy !== 1'b1)
        $display("FAIL post_reset cyc=%0d tx=%b busy=%b required tx=%b busy=1",
                 c, tx_out, busy, exp_q[c]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0)
      $display("FAIL post_reset_end tx=%b busy=%b required tx=1 busy=0", tx_out, busy);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    bit            pe, pt;
    logic [PW-1:0] ps;
    int unsigned   gap;
    for (int f = 0; f < 25; f++) begin
      d  = DW'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = PW'($urandom_range(0, 12));
      exp_q.delete();
      build_frame(d, pe, pt, ps);
      drive_req(d, pe, pt, ps);
      tick();
      data_valid = 1'b0;
      for (int c = 0; c < exp_q.size(); c++) begin
        n_checks++;
        if (tx_out !== exp_q[c] || busy !== 1'b1)
          $display("FAIL random%0d cyc=%0d tx=%b busy=%b required tx=%b busy=1",
                   f, c, tx_out, busy, exp_q[c]);
        else n_pass++;
        scramble_inputs();
`ifndef UART_TX_HOLD_BUF_EN
        data_valid = ($urandom_range(0, 3) == 0);
`endif
        tick();
      end
      data_valid = 1'b0;
      n_checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0)
        $display("FAIL random%0d_end tx=%b busy=%b required tx=1 busy=0", f, tx_out, busy);
      else n_pass++;
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
    end
  endtask

`ifdef UART_TX_HOLD_BUF_EN
  task automatic test_hold_buf();
    exp_q.delete();
    build_frame(8'h11, 1'b0, 1'b0, 8);
    build_frame(8'h22, 1'b0, 1'b0, 8);
    drive_req(8'h11, 1'b0, 1'b0, 6'd8);
    tick();
    data_valid = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      n_checks++;
      if (tx_out !== exp_q[c] || busy !== 1'b1)
        $display("FAIL hold cyc=%0d tx=%b busy=%b required tx=%b busy=1",
                 c, tx_out, busy, exp_q[c]);
      else n_pass++;
      if (c == 5) drive_req(8'h22, 1'b0, 1'b0, 6'd8);
      else if (c == 30) drive_req(8'h33, 1'b1, 1'b1, 6'd2);
      else data_valid = 1'b0;
      tick();
    end
    data_valid = 1'b0;
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0)
      $display("FAIL hold_end tx=%b busy=%b required tx=1 busy=0", tx_out, busy);
    else n_pass++;
    tick();
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
`ifdef UART_TX_HOLD_BUF_EN
    test_hold_buf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
